// File: rtl/iram_arbiter_if.sv
// Bus bundle between the internal-RAM arbiter, its three requesters and the RAM macro.
// The arbiter connects through the slave modport.
interface iram_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              cpu_req, irq_req, dbg_req;
  logic              cpu_we, irq_we, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, irq_addr, dbg_addr;
  logic [DATA_W-1:0] cpu_wdata, irq_wdata, dbg_wdata;
  logic              cpu_gnt, irq_gnt, dbg_gnt;
  logic              cpu_rvalid, irq_rvalid, dbg_rvalid;
  logic [DATA_W-1:0] rdata;
  logic              dbg_excl, dbg_excl_ack, cpu_stall;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  modport slave (
    input  cpu_req, irq_req, dbg_req, cpu_we, irq_we, dbg_we,
    input  cpu_addr, irq_addr, dbg_addr, cpu_wdata, irq_wdata, dbg_wdata,
    input  dbg_excl, ram_rdata,
    output cpu_gnt, irq_gnt, dbg_gnt, cpu_rvalid, irq_rvalid, dbg_rvalid, rdata,
    output dbg_excl_ack, cpu_stall, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output cpu_req, irq_req, dbg_req, cpu_we, irq_we, dbg_we,
    output cpu_addr, irq_addr, dbg_addr, cpu_wdata, irq_wdata, dbg_wdata,
    output dbg_excl, ram_rdata,
    input  cpu_gnt, irq_gnt, dbg_gnt, cpu_rvalid, irq_rvalid, dbg_rvalid, rdata,
    input  dbg_excl_ack, cpu_stall, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/iram_arbiter.sv
// Single-port internal RAM arbiter: cpu priority with starvation override for irq/dbg,
// round-robin between the low ports, and a debug exclusive mode that stalls the cpu.
module iram_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_LIM = 4
) (
  input logic            clock,
  input logic            reset,
  iram_arbiter_if.slave  bus
);
  typedef enum logic [1:0] {StNormal, StDrain, StExcl} mode_e;

  localparam logic [3:0] Lim = 4'(STARVE_LIM);

  mode_e       mode_q;
  logic [3:0]  irq_cnt_q, dbg_cnt_q;
  logic        rr_q;
  logic        cpu_stall_q, excl_ack_q;
  logic [2:0]  tag_q;  // {dbg, irq, cpu} port whose read is returning
  logic [2:0]  gnt;    // {dbg, irq, cpu}
  logic        irq_starved, dbg_starved;
  logic        we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  assign irq_starved = bus.irq_req && (irq_cnt_q == Lim);
  assign dbg_starved = bus.dbg_req && (dbg_cnt_q == Lim);

  always_comb begin
    gnt = 3'b000;
    if (!reset) begin
      case (mode_q)
        StNormal: begin
          if (irq_starved && dbg_starved)        gnt = rr_q ? 3'b100 : 3'b010;
          else if (irq_starved)                  gnt = 3'b010;
          else if (dbg_starved)                  gnt = 3'b100;
          else if (bus.cpu_req)                  gnt = 3'b001;
          else if (bus.irq_req && bus.dbg_req)   gnt = rr_q ? 3'b100 : 3'b010;
          else if (bus.irq_req)                  gnt = 3'b010;
          else if (bus.dbg_req)                  gnt = 3'b100;
        end
        StExcl:  gnt = {bus.dbg_req, 2'b00};
        default: gnt = 3'b000;
      endcase
    end
  end

  always_comb begin
    we_sel    = 1'b0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (gnt[0]) begin
      we_sel = bus.cpu_we; addr_sel = bus.cpu_addr; wdata_sel = bus.cpu_wdata;
    end else if (gnt[1]) begin
      we_sel = bus.irq_we; addr_sel = bus.irq_addr; wdata_sel = bus.irq_wdata;
    end else if (gnt[2]) begin
      we_sel = bus.dbg_we; addr_sel = bus.dbg_addr; wdata_sel = bus.dbg_wdata;
    end
  end

  assign bus.cpu_gnt      = gnt[0];
  assign bus.irq_gnt      = gnt[1];
  assign bus.dbg_gnt      = gnt[2];
  assign bus.ram_en       = |gnt;
  assign bus.ram_we       = we_sel;
  assign bus.ram_addr     = addr_sel;
  assign bus.ram_wdata    = wdata_sel;
  assign bus.rdata        = bus.ram_rdata;
  // Reset squashes a read that is returning in the reset cycle itself.
  assign bus.cpu_rvalid   = tag_q[0] & ~reset;
  assign bus.irq_rvalid   = tag_q[1] & ~reset;
  assign bus.dbg_rvalid   = tag_q[2] & ~reset;
  assign bus.cpu_stall    = cpu_stall_q;
  assign bus.dbg_excl_ack = excl_ack_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q      <= StNormal;
      irq_cnt_q   <= 4'd0;
      dbg_cnt_q   <= 4'd0;
      rr_q        <= 1'b0;
      tag_q       <= 3'b000;
      cpu_stall_q <= 1'b0;
      excl_ack_q  <= 1'b0;
    end else begin
      tag_q <= we_sel ? 3'b000 : gnt;
      if (gnt[1])      rr_q <= 1'b1;
      else if (gnt[2]) rr_q <= 1'b0;

      case (mode_q)
        StNormal: begin
          irq_cnt_q <= (!bus.irq_req || gnt[1]) ? 4'd0 :
                       (irq_cnt_q == Lim) ? Lim : irq_cnt_q + 4'd1;
          dbg_cnt_q <= (!bus.dbg_req || gnt[2]) ? 4'd0 :
                       (dbg_cnt_q == Lim) ? Lim : dbg_cnt_q + 4'd1;
          if (bus.dbg_excl) begin
            mode_q      <= StDrain;
            cpu_stall_q <= 1'b1;
          end
        end
        StDrain: begin
          if (bus.dbg_excl) begin
            mode_q     <= StExcl;
            excl_ack_q <= 1'b1;
          end else begin
            mode_q      <= StNormal;
            cpu_stall_q <= 1'b0;
          end
        end
        StExcl: begin
          if (!bus.dbg_excl) begin
            mode_q      <= StNormal;
            cpu_stall_q <= 1'b0;
            excl_ack_q  <= 1'b0;
          end
        end
        default: begin
          mode_q      <= StNormal;
          cpu_stall_q <= 1'b0;
          excl_ack_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iram_arbiter.sv
// Directed and randomized check of iram_arbiter against a port-level reference model
// (wait counters, round-robin preference, mode, pending read) and a shadow RAM.
module tb_iram_arbiter;
  localparam int unsigned AW  = 8;
  localparam int unsigned DW  = 8;
  localparam int          LIM = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  iram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  iram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // RAM macro: one-cycle registered read
  logic [7:0] ram [256];
  always @(posedge clock) begin
    if (bus.ram_en) begin
      if (bus.ram_we) ram[bus.ram_addr] = bus.ram_wdata;
      else            bus.ram_rdata <= ram[bus.ram_addr];
    end
  end

  // Reference model state: ports 0=cpu 1=irq 2=dbg; mode 0=normal 1=drain 2=excl
  int         m_mode, w_irq, w_dbg, m_rr, pend;
  logic [7:0] pend_data;
  logic [7:0] shadow [256];
  int         checks = 0;
  int         failures = 0;
  logic [2:0] last_gnt, last_rv;
  logic [7:0] last_rdata;
  logic       last_stall, last_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    bit si, sd;
    if (reset || m_mode == 1) return -1;
    if (m_mode == 2) return bus.dbg_req ? 2 : -1;
    si = bus.irq_req && (w_irq == LIM);
    sd = bus.dbg_req && (w_dbg == LIM);
    if (si && sd) return (m_rr == 0) ? 1 : 2;
    if (si) return 1;
    if (sd) return 2;
    if (bus.cpu_req) return 0;
    if (bus.irq_req && bus.dbg_req) return (m_rr == 0) ? 1 : 2;
    if (bus.irq_req) return 1;
    if (bus.dbg_req) return 2;
    return -1;
  endfunction

  task automatic set_idle();
    {bus.cpu_req, bus.irq_req, bus.dbg_req, bus.cpu_we, bus.irq_we, bus.dbg_we} = '0;
    {bus.cpu_addr, bus.irq_addr, bus.dbg_addr} = '0;
    {bus.cpu_wdata, bus.irq_wdata, bus.dbg_wdata} = '0;
    bus.dbg_excl = 1'b0;
  endtask

  // Inputs are applied 1 time unit after the rising edge; outputs are checked mid-cycle.
  task automatic step();
    int g;
    logic we;
    logic [7:0] a, d;
    #4;
    g = pick();
    last_gnt   = {bus.dbg_gnt, bus.irq_gnt, bus.cpu_gnt};
    last_rv    = {bus.dbg_rvalid, bus.irq_rvalid, bus.cpu_rvalid};
    last_rdata = bus.rdata;
    last_stall = bus.cpu_stall;
    last_ack   = bus.dbg_excl_ack;
    case (g)
      0:       begin we = bus.cpu_we; a = bus.cpu_addr; d = bus.cpu_wdata; end
      1:       begin we = bus.irq_we; a = bus.irq_addr; d = bus.irq_wdata; end
      2:       begin we = bus.dbg_we; a = bus.dbg_addr; d = bus.dbg_wdata; end
      default: begin we = 1'b0; a = 8'h00; d = 8'h00; end
    endcase
    chk("cpu_gnt", bus.cpu_gnt, g == 0);
    chk("irq_gnt", bus.irq_gnt, g == 1);
    chk("dbg_gnt", bus.dbg_gnt, g == 2);
    chk("ram_en", bus.ram_en, g >= 0);
    chk("ram_we", bus.ram_we, we);
    chk("ram_addr", bus.ram_addr, a);
    chk("ram_wdata", bus.ram_wdata, d);
    chk("cpu_rvalid", bus.cpu_rvalid, pend == 0 && !reset);
    chk("irq_rvalid", bus.irq_rvalid, pend == 1 && !reset);
    chk("dbg_rvalid", bus.dbg_rvalid, pend == 2 && !reset);
    if (pend >= 0 && !reset) chk("rdata", bus.rdata, pend_data);
    chk("cpu_stall", bus.cpu_stall, m_mode != 0);
    chk("dbg_excl_ack", bus.dbg_excl_ack, m_mode == 2);
    if (reset) begin
      m_mode = 0; w_irq = 0; w_dbg = 0; m_rr = 0; pend = -1;
    end else begin
      pend = -1;
      if (g >= 0 && !we) begin pend = g; pend_data = shadow[a]; end
      if (g >= 0 && we) shadow[a] = d;
      if (m_mode == 0) begin
        w_irq = (!bus.irq_req || g == 1) ? 0 : (w_irq < LIM ? w_irq + 1 : LIM);
        w_dbg = (!bus.dbg_req || g == 2) ? 0 : (w_dbg < LIM ? w_dbg + 1 : LIM);
      end
      if (g == 1) m_rr = 1;
      if (g == 2) m_rr = 0;
      case (m_mode)
        0:       m_mode = bus.dbg_excl ? 1 : 0;
        1:       m_mode = bus.dbg_excl ? 2 : 0;
        default: m_mode = bus.dbg_excl ? 2 : 0;
      endcase
    end
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]    = 8'(i * 5 + 1);
      shadow[i] = 8'(i * 5 + 1);
    end
    ram[5] = 8'h3C; shadow[5] = 8'h3C;
    m_mode = 0; w_irq = 0; w_dbg = 0; m_rr = 0; pend = -1; pend_data = '0;
    set_idle();
    bus.cpu_req = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    step();  // reset held with a pending cpu request: no grant, outputs idle
    chk("reset_gnt", last_gnt, 3'b000);
    chk("reset_stall", last_stall, 1'b0);
    reset = 1'b0;
    set_idle();

    // Priority and read return
    bus.cpu_req = 1; bus.cpu_addr = 8'h05;
    bus.irq_req = 1; bus.irq_addr = 8'h10;
    step();
    chk("prio_gnt", last_gnt, 3'b001);
    bus.cpu_req = 0;
    step();
    chk("prio_rvalid", last_rv, 3'b001);
    chk("prio_rdata", last_rdata, 8'h3C);
    chk("prio_irq_gnt", last_gnt, 3'b010);
    bus.irq_req = 0;
    step();

    // Round-robin between irq and dbg from reset
    do_reset();
    bus.irq_req = 1; bus.dbg_req = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rr_seq", last_gnt, (i % 2 == 0) ? 3'b010 : 3'b100);
    end

    // Starvation override of a continuously requesting cpu
    do_reset();
    bus.cpu_req = 1; bus.cpu_addr = 8'h01; bus.dbg_req = 1; bus.dbg_addr = 8'h02;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("starve_seq", last_gnt, (i == 4) ? 3'b100 : 3'b001);
    end

    // Exclusive mode
    do_reset();
    bus.cpu_req = 1; bus.cpu_addr = 8'h30;
    step(); step();
    bus.dbg_excl = 1;
    step();
    chk("excl_n_stall", last_stall, 1'b0);
    chk("excl_n_gnt", last_gnt, 3'b001);
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 8'h30; bus.dbg_wdata = 8'hA5;
    step();
    chk("excl_n1_stall", last_stall, 1'b1);
    chk("excl_n1_ack", last_ack, 1'b0);
    chk("excl_n1_gnt", last_gnt, 3'b000);
    step();
    chk("excl_n2_ack", last_ack, 1'b1);
    chk("excl_n2_gnt", last_gnt, 3'b100);
    bus.dbg_req = 0; bus.dbg_we = 0;
    step();
    chk("excl_cpu_held", last_gnt, 3'b000);
    bus.dbg_excl = 0;
    step();
    step();
    chk("excl_exit_stall", last_stall, 1'b0);
    chk("excl_cpu_gnt", last_gnt, 3'b001);
    bus.cpu_req = 0;
    step();
    chk("excl_rd_rvalid", last_rv, 3'b001);
    chk("excl_rd_data", last_rdata, 8'hA5);

    // Reset mid-operation
    do_reset();
    bus.dbg_req = 1; bus.dbg_addr = 8'h11;
    step();
    bus.dbg_req = 0;
    bus.irq_req = 1; bus.irq_addr = 8'h40;
    step();
    chk("rst_irq_gnt", last_gnt, 3'b010);
    bus.irq_req = 0;
    reset = 1;
    step();
    chk("rst_kill_rvalid", last_rv, 3'b000);
    reset = 0;
    bus.irq_req = 1; bus.dbg_req = 1;
    step();
    chk("rst_rr_cleared", last_gnt, 3'b010);

    // Randomized traffic
    set_idle();
    for (int i = 0; i < 400; i++) begin
      bus.cpu_req   = ($urandom_range(0, 3) != 0);
      bus.irq_req   = ($urandom_range(0, 2) == 0);
      bus.dbg_req   = ($urandom_range(0, 2) == 0);
      bus.cpu_we    = $urandom_range(0, 1) == 1;
      bus.irq_we    = $urandom_range(0, 1) == 1;
      bus.dbg_we    = $urandom_range(0, 1) == 1;
      bus.cpu_addr  = 8'($urandom_range(0, 15));
      bus.irq_addr  = 8'($urandom_range(0, 15));
      bus.dbg_addr  = 8'($urandom_range(0, 15));
      bus.cpu_wdata = 8'($urandom);
      bus.irq_wdata = 8'($urandom);
      bus.dbg_wdata = 8'($urandom);
      if ($urandom_range(0, 15) == 0) bus.dbg_excl = ~bus.dbg_excl;
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 0;
    set_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
